// File: rtl/mem_ctrl.sv
// Byte-wide RAM/IO port arbiter: serialises fetcher word reads and LSB
// loads/stores into per-byte accesses and returns one-cycle done pulses.
module mem_ctrl #(
  parameter int          ADDR_W = 32,
  parameter logic [1:0]  IO_HI  = 2'b11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              in_fetcher_ce,
  input  logic [ADDR_W-1:0] in_fetcher_addr,
  output logic              out_fetcher_ce,
  output logic [31:0]       out_fetcher_data,
  input  logic              in_lsb_ce,
  input  logic              in_lsb_wr,
  input  logic [ADDR_W-1:0] in_lsb_addr,
  input  logic [1:0]        in_lsb_size,
  input  logic [31:0]       in_lsb_data,
  output logic              out_lsb_ce,
  output logic [31:0]       out_lsb_data,
  input  logic              in_clear,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr,
  input  logic              io_buffer_full
);
  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;
  state_t state, state_nx;

  logic              f_v;
  logic [ADDR_W-1:0] f_addr;
  logic              l_v, l_wr;
  logic [ADDR_W-1:0] l_addr;
  logic [1:0]        l_size;
  logic [31:0]       l_data;

  logic              cur_lsb;
  logic [ADDR_W-1:0] cur_addr;
  logic [2:0]        cur_len;
  logic [31:0]       cur_data;
  logic [31:0]       rbuf;
  logic [2:0]        k;
  logic              wr_q;

  logic              lsb_pend, lsb_pend_wr, fetch_pend, start_lsb, start_fetch;
  logic [ADDR_W-1:0] sel_addr;
  logic [1:0]        sel_size;
  logic [2:0]        sel_len;
  logic [31:0]       sel_data;
  logic              io_stall, rd_last, wr_last;
  logic [2:0]        k_inc;
  logic [31:0]       rd_nx;
  logic [7:0]        wbyte;

  // A pulse arriving in IDLE counts as pending immediately; a clear discards
  // it, and also drops a held load but never a held (committed) store.
  always_comb begin
    lsb_pend    = (l_v & (l_wr | ~in_clear)) | (~l_v & in_lsb_ce & ~in_clear);
    lsb_pend_wr = l_v ? l_wr : in_lsb_wr;
    fetch_pend  = ~in_clear & (f_v | in_fetcher_ce);
    start_lsb   = (state == IDLE) & lsb_pend;
    start_fetch = (state == IDLE) & ~lsb_pend & fetch_pend;
    sel_size    = l_v ? l_size : in_lsb_size;
    sel_data    = l_v ? l_data : in_lsb_data;
    sel_addr    = start_lsb ? (l_v ? l_addr : in_lsb_addr)
                            : (f_v ? f_addr : in_fetcher_addr);
    case (sel_size)
      2'b00:   sel_len = 3'd1;
      2'b01:   sel_len = 3'd2;
      default: sel_len = 3'd4;
    endcase
    if (!start_lsb) sel_len = 3'd4;
    io_stall = (state == WRITE) & (cur_addr[17:16] == IO_HI) & io_buffer_full;
    rd_last  = (state == READ) & (k == cur_len);
    wr_last  = (state == WRITE) & ~io_stall & (k == cur_len - 3'd1);
    k_inc    = k + 3'd1;
  end

  // Byte k-1 of a read arrives while the counter reads k.
  always_comb begin
    rd_nx = rbuf;
    case (k)
      3'd1:    rd_nx[7:0]   = mem_din;
      3'd2:    rd_nx[15:8]  = mem_din;
      3'd3:    rd_nx[23:16] = mem_din;
      3'd4:    rd_nx[31:24] = mem_din;
      default: rd_nx = rbuf;
    endcase
    case (k_inc)
      3'd1:    wbyte = cur_data[15:8];
      3'd2:    wbyte = cur_data[23:16];
      3'd3:    wbyte = cur_data[31:24];
      default: wbyte = cur_data[7:0];
    endcase
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (start_lsb)        state_nx = lsb_pend_wr ? WRITE : READ;
        else if (start_fetch) state_nx = READ;
      end
      READ:    if (in_clear || rd_last) state_nx = IDLE;
      WRITE:   if (wr_last) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      state <= IDLE;
    else if (rdy) state <= state_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f_v <= 1'b0; f_addr <= '0;
      l_v <= 1'b0; l_wr <= 1'b0; l_addr <= '0; l_size <= 2'b00; l_data <= '0;
      cur_lsb <= 1'b0; cur_addr <= '0; cur_len <= 3'd0; cur_data <= '0;
      rbuf <= '0; k <= 3'd0; wr_q <= 1'b0;
      mem_a <= '0; mem_dout <= 8'h00;
      out_fetcher_ce <= 1'b0; out_fetcher_data <= '0;
      out_lsb_ce <= 1'b0; out_lsb_data <= '0;
    end else if (rdy) begin
      out_fetcher_ce <= 1'b0;
      out_lsb_ce     <= 1'b0;

      if (start_fetch)        f_v <= 1'b0;
      else if (in_clear)      f_v <= 1'b0;
      else if (in_fetcher_ce) begin
        f_v <= 1'b1; f_addr <= in_fetcher_addr;
      end

      if (start_lsb) l_v <= 1'b0;
      else if (in_clear) begin
        if (!l_wr) l_v <= 1'b0;
      end else if (in_lsb_ce) begin
        l_v <= 1'b1; l_wr <= in_lsb_wr; l_addr <= in_lsb_addr;
        l_size <= in_lsb_size; l_data <= in_lsb_data;
      end

      case (state)
        IDLE: begin
          if (start_lsb || start_fetch) begin
            cur_lsb  <= start_lsb;
            cur_addr <= sel_addr;
            cur_len  <= sel_len;
            cur_data <= sel_data;
            rbuf     <= '0;
            k        <= 3'd0;
            mem_a    <= sel_addr;
            if (start_lsb && lsb_pend_wr) begin
              wr_q     <= 1'b1;
              mem_dout <= sel_data[7:0];
            end
          end
        end
        READ: begin
          if (!in_clear) begin
            rbuf <= rd_nx;
            k    <= k_inc;
            if (k_inc < cur_len) mem_a <= cur_addr + ADDR_W'(k_inc);
            if (rd_last) begin
              if (cur_lsb) begin
                out_lsb_ce <= 1'b1; out_lsb_data <= rd_nx;
              end else begin
                out_fetcher_ce <= 1'b1; out_fetcher_data <= rd_nx;
              end
            end
          end
        end
        WRITE: begin
          if (!io_stall) begin
            if (wr_last) begin
              wr_q         <= 1'b0;
              out_lsb_ce   <= 1'b1;
              out_lsb_data <= '0;
            end else begin
              k        <= k_inc;
              mem_a    <= cur_addr + ADDR_W'(k_inc);
              mem_dout <= wbyte;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_wr = wr_q & rdy & ~io_stall;
endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: directed scenarios plus randomized single requests,
// checked against a byte-addressed memory model and per-cycle timing rules.
module tb_mem_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdy = 1'b1;
  logic        in_fetcher_ce = 1'b0;
  logic [31:0] in_fetcher_addr = '0;
  logic        out_fetcher_ce;
  logic [31:0] out_fetcher_data;
  logic        in_lsb_ce = 1'b0;
  logic        in_lsb_wr = 1'b0;
  logic [31:0] in_lsb_addr = '0;
  logic [1:0]  in_lsb_size = 2'b00;
  logic [31:0] in_lsb_data = '0;
  logic        out_lsb_ce;
  logic [31:0] out_lsb_data;
  logic        in_clear = 1'b0;
  logic [7:0]  mem_din = 8'h00;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full = 1'b0;

  int nvec = 0;
  int nerr = 0;

  logic [7:0] ram     [logic [31:0]];
  logic [7:0] ref_mem [logic [31:0]];

  mem_ctrl #(.ADDR_W(32), .IO_HI(2'b11)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .in_fetcher_ce(in_fetcher_ce), .in_fetcher_addr(in_fetcher_addr),
    .out_fetcher_ce(out_fetcher_ce), .out_fetcher_data(out_fetcher_data),
    .in_lsb_ce(in_lsb_ce), .in_lsb_wr(in_lsb_wr), .in_lsb_addr(in_lsb_addr),
    .in_lsb_size(in_lsb_size), .in_lsb_data(in_lsb_data),
    .out_lsb_ce(out_lsb_ce), .out_lsb_data(out_lsb_data),
    .in_clear(in_clear), .mem_din(mem_din), .mem_dout(mem_dout),
    .mem_a(mem_a), .mem_wr(mem_wr), .io_buffer_full(io_buffer_full)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] dflt(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ a[31:24] ^ 8'h5A;
  endfunction

  function automatic logic [7:0] env_rd(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : dflt(a);
  endfunction

  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a, input int n);
    logic [31:0] v = '0;
    for (int i = 0; i < n; i++) v |= 32'(ref_rd(a + 32'(i))) << (8 * i);
    return v;
  endfunction

  // RAM next to the port: one-cycle read latency, frozen with rdy.
  always @(posedge clk) begin
    if (rdy) begin
      mem_din <= env_rd(mem_a);
      if (mem_wr) ram[mem_a] = mem_dout;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [31:0] a, input logic [7:0] b);
    ram[a] = b;
    ref_mem[a] = b;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_fce"}, out_fetcher_ce, 0);
    chk({tag, "_fdata"}, out_fetcher_data, 0);
    chk({tag, "_lce"}, out_lsb_ce, 0);
    chk({tag, "_ldata"}, out_lsb_data, 0);
    chk({tag, "_dout"}, mem_dout, 0);
    chk({tag, "_a"}, mem_a, 0);
    chk({tag, "_wr"}, mem_wr, 0);
  endtask

  // One isolated request pulsed in cycle 0; io_buffer_full high in cycles
  // 1..stall, rdy low in cycle hold (0 = never).
  task automatic txn(input bit is_f, input bit wr_in, input logic [31:0] addr,
                     input logic [1:0] size, input logic [31:0] data,
                     input int stall, input int hold);
    int n, s, d, e, last;
    bit wr, w;
    logic [31:0] expd;
    wr   = wr_in && !is_f;
    n    = is_f ? 4 : (size == 2'd0 ? 1 : (size == 2'd1 ? 2 : 4));
    s    = (wr && addr[17:16] == 2'b11) ? stall : 0;
    expd = wr ? 32'h0 : ref_word(addr, n);
    d    = wr ? s + n + 1 : n + 2;
    last = d + 1 + (hold != 0 ? 1 : 0);
    if (is_f) begin
      in_fetcher_ce = 1'b1; in_fetcher_addr = addr;
    end else begin
      in_lsb_ce = 1'b1; in_lsb_wr = wr; in_lsb_addr = addr;
      in_lsb_size = size; in_lsb_data = data;
    end
    for (int c = 1; c <= last; c++) begin
      tick();
      in_fetcher_ce  = 1'b0;
      in_lsb_ce      = 1'b0;
      io_buffer_full = (c <= stall);
      rdy            = (c != hold);
      #1;
      e = (hold != 0 && c > hold) ? c - 1 : c;
      if (wr) begin
        w = (e > s) && (e <= s + n) && (c != hold);
        chk("wr_strobe", mem_wr, w);
        if (w) begin
          chk("wr_addr", mem_a, addr + 32'(e - s - 1));
          chk("wr_byte", mem_dout, (data >> (8 * (e - s - 1))) & 32'hFF);
        end
      end else begin
        chk("rd_nowr", mem_wr, 0);
        if (e >= 1 && e <= n) chk("rd_addr", mem_a, addr + 32'(e - 1));
      end
      chk("fetch_ce", out_fetcher_ce, is_f && e == d);
      chk("lsb_ce", out_lsb_ce, !is_f && e == d);
      if (e == d) begin
        if (is_f) chk("fetch_data", out_fetcher_data, expd);
        else      chk("lsb_data", out_lsb_data, expd);
      end
    end
    io_buffer_full = 1'b0;
    rdy = 1'b1;
    if (wr) for (int i = 0; i < n; i++) ref_mem[addr + 32'(i)] = 8'((data >> (8 * i)) & 32'hFF);
  endtask

  initial begin
    logic [31:0] ra, rd;
    bit rf, rw;
    logic [1:0] rs;
    int st, ho, sel;

    preload(32'h1000, 8'h13); preload(32'h1001, 8'h05);
    preload(32'h1002, 8'h00); preload(32'h1003, 8'h00);
    preload(32'h2002, 8'hAB); preload(32'h2003, 8'hCD);

    // Reset state
    tick(); tick();
    chk_zero("reset");
    rst = 1'b0;
    tick();

    // Word fetch of a known instruction
    txn(1, 0, 32'h1000, 2'b10, 32'h0, 0, 0);
    chk("fetch_insn", out_fetcher_data, 32'h0000_0513);

    // Halfword load
    txn(0, 0, 32'h2002, 2'b01, 32'h0, 0, 0);
    chk("half_load", out_lsb_data, 32'h0000_CDAB);

    // Word store, then inspect the RAM itself
    txn(0, 1, 32'h40, 2'b10, 32'h1122_3344, 0, 0);
    chk("ram40", env_rd(32'h40), 32'h44);
    chk("ram41", env_rd(32'h41), 32'h33);
    chk("ram42", env_rd(32'h42), 32'h22);
    chk("ram43", env_rd(32'h43), 32'h11);

    // Simultaneous fetch and byte load: LSB first, fetch right behind
    in_fetcher_ce = 1'b1; in_fetcher_addr = 32'h1000;
    in_lsb_ce = 1'b1; in_lsb_wr = 1'b0; in_lsb_addr = 32'h2003; in_lsb_size = 2'b00;
    for (int c = 1; c <= 10; c++) begin
      tick();
      in_fetcher_ce = 1'b0; in_lsb_ce = 1'b0;
      #1;
      if (c == 1) chk("arb_lsb_addr", mem_a, 32'h2003);
      if (c >= 4 && c <= 7) chk("arb_fetch_addr", mem_a, 32'h1000 + 32'(c - 4));
      chk("arb_lsb_ce", out_lsb_ce, c == 3);
      chk("arb_fetch_ce", out_fetcher_ce, c == 9);
      if (c == 3) chk("arb_lsb_data", out_lsb_data, 32'hCD);
      if (c == 9) chk("arb_fetch_data", out_fetcher_data, 32'h0000_0513);
    end

    // IO store held off by a full buffer
    txn(0, 1, 32'h0003_0000, 2'b00, 32'h41, 3, 0);

    // Flush aborts an in-flight fetch; a later fetch starts cleanly
    in_fetcher_ce = 1'b1; in_fetcher_addr = 32'h1000;
    for (int c = 1; c <= 12; c++) begin
      tick();
      in_fetcher_ce = (c == 5); in_fetcher_addr = 32'h2000;
      in_clear = (c == 3);
      #1;
      chk("clr_fetch_ce", out_fetcher_ce, c == 11);
      if (c >= 6 && c <= 9) chk("clr_new_addr", mem_a, 32'h2000 + 32'(c - 6));
      if (c == 11) chk("clr_new_data", out_fetcher_data, ref_word(32'h2000, 4));
    end
    in_clear = 1'b0;

    // Store queued behind a fetch; a flush during the store leaves it intact
    in_fetcher_ce = 1'b1; in_fetcher_addr = 32'h1000;
    for (int c = 1; c <= 9; c++) begin
      tick();
      in_fetcher_ce = 1'b0;
      in_lsb_ce = (c == 2); in_lsb_wr = 1'b1; in_lsb_addr = 32'h60;
      in_lsb_size = 2'b00; in_lsb_data = 32'hDEAD_BE7E;
      in_clear = (c == 7);
      #1;
      chk("b2b_fetch_ce", out_fetcher_ce, c == 6);
      chk("b2b_lsb_ce", out_lsb_ce, c == 8);
      chk("b2b_wr", mem_wr, c == 7);
      if (c == 6) chk("b2b_fetch_data", out_fetcher_data, 32'h0000_0513);
      if (c == 7) begin
        chk("b2b_wr_addr", mem_a, 32'h60);
        chk("b2b_wr_byte", mem_dout, 32'h7E);
      end
    end
    in_clear = 1'b0; in_lsb_wr = 1'b0;
    ref_mem[32'h60] = 8'h7E;
    chk("b2b_ram", env_rd(32'h60), 32'h7E);

    // Stalls from rdy during a fetch and a store
    txn(1, 0, 32'h1000, 2'b10, 32'h0, 0, 2);
    txn(0, 1, 32'h80, 2'b10, 32'hA1B2_C3D4, 0, 2);
    txn(0, 0, 32'h80, 2'b10, 32'h0, 0, 0);
    chk("rdy_store_word", out_lsb_data, 32'hA1B2_C3D4);

    // Asynchronous reset in the middle of a word load
    in_lsb_ce = 1'b1; in_lsb_wr = 1'b0; in_lsb_addr = 32'h5000; in_lsb_size = 2'b10;
    tick();
    in_lsb_ce = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    chk_zero("midrst");
    tick();
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick();
      chk("midrst_lce", out_lsb_ce, 0);
      chk("midrst_fce", out_fetcher_ce, 0);
      chk("midrst_wr", mem_wr, 0);
    end

    // Randomized single requests against the memory model
    for (int t = 0; t < 40; t++) begin
      rf  = ($urandom_range(0, 2) == 0);
      rw  = !rf && ($urandom_range(0, 1) == 1);
      rs  = 2'($urandom_range(0, 2));
      rd  = $urandom;
      sel = $urandom_range(0, 3);
      case (sel)
        0:       ra = $urandom;
        1:       ra = 32'h0003_0000 | 32'($urandom_range(0, 15));
        2:       ra = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
        default: ra = 32'($urandom_range(0, 31));
      endcase
      st = $urandom_range(0, 3);
      ho = (st == 0 && $urandom_range(0, 1) == 1) ? $urandom_range(1, 4) : 0;
      txn(rf, rw, ra, rs, rd, st, ho);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
